readout_pipeline_nlane: RTL and testbench

Parametrised, self-sequencing qubit-readout datapath. It runs trigger-to-sample delay, windowed capture of LANES samples per clock, digital demodulation by a LUT-based phase accumulator, and I/Q integration. It adds optional multi-shot averaging and a valid/ready result FIFO. It replaces the fixed 5-lane timing/sampler/multiplier/integrator chain and feeds the downstream state analyzer.

---
 rtl/readout_pipeline_nlane.sv | 239 +++++++++++++++++++++++
 tb/tb_readout_pipeline_nlane.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/readout_pipeline_nlane.sv
// Triggered multi-lane qubit readout: delay, window capture, LUT demodulation,
// I/Q integration, multi-shot averaging and a first-word-fall-through result FIFO.
module readout_pipeline_nlane #(
   parameter int LANES      = 5,
   parameter int DATA_W     = 16,
   parameter int PHASE_W    = 4,
   parameter int ACC_W      = 64,
   parameter int LEN_W      = 16,
   parameter int DELAY_W    = 14,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk100,
   input  logic                      reset,
   input  logic                      trigger,
   input  logic [LANES*DATA_W-1:0]   data_i_in,
   input  logic [LANES*DATA_W-1:0]   data_q_in,
   input  logic [DELAY_W-1:0]        cfg_delay,
   input  logic [LEN_W-1:0]          cfg_length,
   input  logic [PHASE_W-1:0]        cfg_phase_step,
   input  logic [2:0]                cfg_avg_log2,
   output logic                      busy,
   output logic                      trig_missed,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [ACC_W-1:0]   i_out,
   output logic signed [ACC_W-1:0]   q_out,
   output logic                      overflow
);
   localparam int PW = DATA_W + 16;
   localparam int RW = PW + 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_DELAY, S_COLLECT, S_DRAIN, S_DONE
   } state_t;

   state_t r_state, w_next;

   logic                     r_trig_q, w_edge, w_cap, w_push;
   logic                     r_missed, r_ovf, r_dr, r_s1_v;
   logic                     w_pop, w_wr, w_full, w_empty;
   logic [DELAY_W-1:0]       r_delay, r_dcnt;
   logic [LEN_W-1:0]         r_len, r_ccnt;
   logic [PHASE_W-1:0]       r_step, r_ph;
   logic [2:0]               r_avg;
   logic [7:0]               r_shot;
   logic signed [RW-1:0]     w_irot [LANES];
   logic signed [RW-1:0]     w_qrot [LANES];
   logic signed [RW-1:0]     r_irot [LANES];
   logic signed [RW-1:0]     r_qrot [LANES];
   logic signed [ACC_W-1:0]  r_acc_i, r_acc_q, w_isum, w_qsum;
   logic signed [ACC_W-1:0]  w_res_i, w_res_q;
   logic signed [ACC_W-1:0]  r_fi [FIFO_DEPTH];
   logic signed [ACC_W-1:0]  r_fq [FIFO_DEPTH];
   logic [AW:0]              r_wp, r_rp;

   // Q1.14 cosine at k*22.5 degrees; narrower phase indices are scaled up
   function automatic logic signed [15:0] cos16(input logic [3:0] j);
      case (j)
         4'd0:    cos16 = 16'sd16384;
         4'd1:    cos16 = 16'sd15137;
         4'd2:    cos16 = 16'sd11585;
         4'd3:    cos16 = 16'sd6270;
         4'd4:    cos16 = 16'sd0;
         4'd5:    cos16 = -16'sd6270;
         4'd6:    cos16 = -16'sd11585;
         4'd7:    cos16 = -16'sd15137;
         4'd8:    cos16 = -16'sd16384;
         4'd9:    cos16 = -16'sd15137;
         4'd10:   cos16 = -16'sd11585;
         4'd11:   cos16 = -16'sd6270;
         4'd12:   cos16 = 16'sd0;
         4'd13:   cos16 = 16'sd6270;
         4'd14:   cos16 = 16'sd11585;
         default: cos16 = 16'sd15137;
      endcase
   endfunction

   function automatic logic [3:0] lut_idx(input logic [PHASE_W-1:0] p);
      return 4'(32'(p) << (4 - PHASE_W));
   endfunction

   assign w_edge = trigger & ~r_trig_q;

   always_ff @(posedge clk100) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:
            if (w_edge)
               w_next = (cfg_delay == '0) ? S_COLLECT : S_DELAY;
         S_DELAY:
            if (r_dcnt == r_delay - DELAY_W'(1)) w_next = S_COLLECT;
         S_COLLECT:
            if (r_ccnt == r_len - LEN_W'(1)) w_next = S_DRAIN;
         S_DRAIN:
            if (r_dr) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (r_state != S_IDLE);
      w_cap  = (r_state == S_COLLECT);
      w_push = (r_state == S_DONE) && (r_shot >= (8'd1 << r_avg));
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_trig_q <= 1'b0;
         r_missed <= 1'b0;
         r_delay  <= '0;
         r_len    <= '0;
         r_step   <= '0;
         r_avg    <= '0;
         r_dcnt   <= '0;
         r_ccnt   <= '0;
         r_ph     <= '0;
         r_dr     <= 1'b0;
         r_shot   <= '0;
      end else begin
         r_trig_q <= trigger;
         r_missed <= w_edge && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               r_dcnt <= '0;
               r_ccnt <= '0;
               r_ph   <= '0;
               r_dr   <= 1'b0;
               if (w_edge) begin
                  r_delay <= cfg_delay;
                  r_len   <= (cfg_length == '0) ? LEN_W'(1) : cfg_length;
                  r_step  <= cfg_phase_step;
                  r_avg   <= cfg_avg_log2;
               end
            end
            S_DELAY: r_dcnt <= r_dcnt + DELAY_W'(1);
            S_COLLECT: begin
               r_ccnt <= r_ccnt + LEN_W'(1);
               r_ph   <= r_ph + PHASE_W'(LANES) * r_step;
            end
            S_DRAIN: begin
               r_dr <= ~r_dr;
               if (r_dr) r_shot <= r_shot + 8'd1;
            end
            S_DONE: if (w_push) r_shot <= '0;
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [PHASE_W-1:0]       w_ph;
      logic signed [15:0]       w_c, w_s;
      logic signed [DATA_W-1:0] w_di, w_dq;
      assign w_ph = r_ph + PHASE_W'(k) * r_step;
      assign w_c  = cos16(lut_idx(w_ph));
      assign w_s  = cos16(lut_idx(w_ph) + 4'd12);
      assign w_di = data_i_in[k*DATA_W +: DATA_W];
      assign w_dq = data_q_in[k*DATA_W +: DATA_W];
      assign w_irot[k] = RW'(PW'(w_di) * PW'(w_c))
                       + RW'(PW'(w_dq) * PW'(w_s));
      assign w_qrot[k] = RW'(PW'(w_dq) * PW'(w_c))
                       - RW'(PW'(w_di) * PW'(w_s));
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_s1_v <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            r_irot[k] <= '0;
            r_qrot[k] <= '0;
         end
      end else begin
         r_s1_v <= w_cap;
         r_irot <= w_irot;
         r_qrot <= w_qrot;
      end
   end

   always_comb begin
      w_isum = '0;
      w_qsum = '0;
      for (int k = 0; k < LANES; k++) begin
         w_isum = w_isum + ACC_W'(r_irot[k]);
         w_qsum = w_qsum + ACC_W'(r_qrot[k]);
      end
   end

   always_ff @(posedge clk100) begin
      if (reset || w_push) begin
         r_acc_i <= '0;
         r_acc_q <= '0;
      end else if (r_s1_v) begin
         r_acc_i <= r_acc_i + w_isum;
         r_acc_q <= r_acc_q + w_qsum;
      end
   end

   assign w_res_i = r_acc_i >>> r_avg;
   assign w_res_q = r_acc_q >>> r_avg;

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW])
                 && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop   = out_valid & out_ready;
   // a pop frees the head slot in the same cycle, so a full FIFO still accepts
   assign w_wr    = w_push & (~w_full | w_pop);

   always_ff @(posedge clk100) begin
      if (w_wr) begin
         r_fi[r_wp[AW-1:0]] <= w_res_i;
         r_fq[r_wp[AW-1:0]] <= w_res_q;
      end
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_wr)  r_wp <= r_wp + (AW+1)'(1);
         if (w_pop) r_rp <= r_rp + (AW+1)'(1);
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   assign out_valid   = ~w_empty;
   assign i_out       = out_valid ? r_fi[r_rp[AW-1:0]] : '0;
   assign q_out       = out_valid ? r_fq[r_rp[AW-1:0]] : '0;
   assign overflow    = r_ovf;
   assign trig_missed = r_missed;
endmodule

// File: tb/tb_readout_pipeline_nlane.sv
// Directed bench for readout_pipeline_nlane: timing, demodulation,
// averaging, FIFO overflow, missed triggers and mid-shot reset.
module tb_readout_pipeline_nlane;
   localparam int LANES = 5;
   localparam int DW    = 16;

   logic                   clk100 = 1'b0;
   logic                   reset;
   logic                   trigger;
   logic [LANES*DW-1:0]    data_i_in, data_q_in;
   logic [13:0]            cfg_delay;
   logic [15:0]            cfg_length;
   logic [3:0]             cfg_phase_step;
   logic [2:0]             cfg_avg_log2;
   logic                   busy, trig_missed, out_valid, out_ready, overflow;
   logic signed [63:0]     i_out, q_out;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   readout_pipeline_nlane dut (
      .clk100(clk100), .reset(reset), .trigger(trigger),
      .data_i_in(data_i_in), .data_q_in(data_q_in),
      .cfg_delay(cfg_delay), .cfg_length(cfg_length),
      .cfg_phase_step(cfg_phase_step), .cfg_avg_log2(cfg_avg_log2),
      .busy(busy), .trig_missed(trig_missed), .out_valid(out_valid),
      .out_ready(out_ready), .i_out(i_out), .q_out(q_out),
      .overflow(overflow)
   );

   always #5 clk100 = ~clk100;

   task automatic tick(input int n);
      repeat (n) @(posedge clk100);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic set_data(input int iv, input int qv);
      for (int k = 0; k < LANES; k++) begin
         data_i_in[k*DW +: DW] = 16'(iv);
         data_q_in[k*DW +: DW] = 16'(qv);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         tick(1);
         n++;
      end
      chk("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 300) begin
         tick(1);
         n++;
      end
      chk("valid_timeout", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic shot(input int iv, input int dly, input int len,
                       input int step, input int avg);
      set_data(iv, 0);
      cfg_delay      = 14'(dly);
      cfg_length     = 16'(len);
      cfg_phase_step = 4'(step);
      cfg_avg_log2   = 3'(avg);
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
      wait_idle();
      tick(1);
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   logic signed [63:0] exp4 [4];

   initial begin
      reset = 1'b1; trigger = 1'b0; out_ready = 1'b0;
      set_data(0, 0);
      cfg_delay = '0; cfg_length = '0;
      cfg_phase_step = '0; cfg_avg_log2 = '0;
      tick(2);
      reset = 1'b0;
      tick(1);
      chk("rst_busy",   {63'd0, busy},        64'd0);
      chk("rst_missed", {63'd0, trig_missed}, 64'd0);
      chk("rst_valid",  {63'd0, out_valid},   64'd0);
      chk("rst_i",      i_out,                64'd0);
      chk("rst_q",      q_out,                64'd0);
      chk("rst_ovf",    {63'd0, overflow},    64'd0);

      // single shot, timing checked against the trigger edge
      set_data(100, 0);
      cfg_delay = 14'd3; cfg_length = 16'd10;
      cfg_phase_step = 4'd0; cfg_avg_log2 = 3'd0;
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
      chk("t1_busy_start", {63'd0, busy}, 64'd1);
      tick(15);
      chk("t1_novalid_e3", {63'd0, out_valid}, 64'd0);
      chk("t1_busy_e3",    {63'd0, busy},      64'd1);
      tick(1);
      chk("t1_valid_e4",   {63'd0, out_valid}, 64'd1);
      chk("t1_idle_e4",    {63'd0, busy},      64'd0);
      chk("t1_i", i_out, 64'sd81920000);
      chk("t1_q", q_out, 64'sd0);
      pop();
      chk("t1_popped", {63'd0, out_valid}, 64'd0);

      // 90 degree phase step
      shot(100, 2, 10, 4, 0);
      wait_valid();
      chk("t2_i", i_out, 64'sd1638400);
      chk("t2_q", q_out, -64'sd1638400);
      pop();

      // four-shot average
      shot(100, 0, 1, 0, 2);
      chk("t3_nov1", {63'd0, out_valid}, 64'd0);
      shot(200, 0, 1, 0, 2);
      chk("t3_nov2", {63'd0, out_valid}, 64'd0);
      shot(300, 0, 1, 0, 2);
      chk("t3_nov3", {63'd0, out_valid}, 64'd0);
      shot(400, 0, 1, 0, 2);
      wait_valid();
      chk("t3_i", i_out, 64'sd20480000);
      chk("t3_q", q_out, 64'sd0);
      pop();

      // FIFO fill and overflow with consumer stalled
      exp4[0] = 64'sd819200;  exp4[1] = 64'sd1638400;
      exp4[2] = 64'sd2457600; exp4[3] = 64'sd3276800;
      shot(10, 0, 1, 0, 0);
      chk("t4_valid1", {63'd0, out_valid}, 64'd1);
      shot(20, 0, 1, 0, 0);
      shot(30, 0, 1, 0, 0);
      shot(40, 0, 1, 0, 0);
      chk("t4_noovf4", {63'd0, overflow}, 64'd0);
      shot(50, 0, 1, 0, 0);
      chk("t4_ovf5", {63'd0, overflow}, 64'd1);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("t4_head%0d", j), i_out, exp4[j]);
         tick(1);
      end
      out_ready = 1'b0;
      chk("t4_empty", {63'd0, out_valid}, 64'd0);

      // second edge during collection
      set_data(100, 0);
      cfg_delay = 14'd0; cfg_length = 16'd10;
      cfg_phase_step = 4'd0; cfg_avg_log2 = 3'd0;
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
      tick(1);
      trigger = 1'b1;
      tick(1);
      chk("t5_missed", {63'd0, trig_missed}, 64'd1);
      trigger = 1'b0;
      tick(1);
      chk("t5_pulse_end", {63'd0, trig_missed}, 64'd0);
      wait_valid();
      chk("t5_i", i_out, 64'sd81920000);
      pop();
      tick(30);
      chk("t5_one_result", {63'd0, out_valid}, 64'd0);

      // reset mid-shot discards partial average
      shot(999, 0, 10, 0, 1);
      chk("t6_nov_a", {63'd0, out_valid}, 64'd0);
      set_data(500, 0);
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6_rst_busy",  {63'd0, busy},      64'd0);
      chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_rst_ovf",   {63'd0, overflow},  64'd0);
      chk("t6_rst_i",     i_out,              64'd0);
      shot(100, 0, 10, 0, 1);
      chk("t6_nov_c", {63'd0, out_valid}, 64'd0);
      shot(300, 0, 10, 0, 1);
      wait_valid();
      chk("t6_i", i_out, 64'sd163840000);
      chk("t6_q", q_out, 64'sd0);
      pop();
      chk("t6_empty", {63'd0, out_valid}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
